// File: rtl/alu_pkg.sv
// ============================================================================
// Package     : alu_pkg
// Description : Shared definitions for the multi-byte ALU sequencer.
//               Contains ALU opcodes, command bit positions and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Opcodes understood by the 8-bit combinational ALU
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_PASS = 4'd4;

  // Bit positions inside the 2-bit command word
  localparam int CMD_SUB = 1;
  localparam int CMD_CIN = 0;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
// Interface   : alu_seq_if
// Description : Command, ALU-port and result signals of the ALU sequencer.
//               master = sequencer side, slave = controller/ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  // command channel
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_cmd;
  logic         in_cin;

  // 8-bit ALU port
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_carry;
  logic [3:0]   alu_op;
  logic [7:0]   alu_c;
  logic         alu_carry_out;
  logic         alu_zero;

  // result channel and status
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         busy;

  modport master (
    input  in_valid, in_a, in_b, in_cmd, in_cin,
    input  alu_c, alu_carry_out, alu_zero,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_carry, alu_op,
    output out_valid, out_result, out_carry, out_zero, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_cmd, in_cin,
    output alu_c, alu_carry_out, alu_zero,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_carry, alu_op,
    input  out_valid, out_result, out_carry, out_zero, busy
  );

endinterface

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module      : alu_seq_ctrl
// Description : FSM, byte index counter and handshake flags of alu_seq.
//               Optional ALU_SEQ_FLUSH_EN adds a flush input that aborts
//               RUN/DONE back to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IDX_W  = $clog2(NBYTES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             accept,
  output logic             run,
  output logic             last,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t state;
  logic   kill;

`ifdef ALU_SEQ_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign run    = (state == S_RUN);
  // a flushed final byte must not publish a result
  assign last   = run && (idx == LAST_IDX) && !kill;

  // Sequencer FSM with registered handshake and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (kill && (state != S_IDLE)) begin
      state     <= S_IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_RUN;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          if (idx == LAST_IDX) begin
            state     <= S_DONE;
            idx       <= '0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          idx       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Multi-byte add/sub sequencer driving an external 8-bit ALU,
//               LSB byte first with carry chaining. Holds operand, result
//               and flag registers plus byte-lane muxes.
//               Optional feature macro: ALU_SEQ_FLUSH_EN (adds flush input).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef ALU_SEQ_FLUSH_EN
  input  logic       flush,
`endif
  alu_seq_if.master  bus
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES) + 1;

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             accept;
  logic             run;
  logic             last;
  logic [IDX_W-1:0] idx;

  logic [W-1:0]     a_hold;
  logic [W-1:0]     b_hold;
  logic             sub_hold;
  logic             cin_en_hold;
  logic             carry_reg;
  logic             zero_acc;
  logic [W-1:0]     res_work;
  logic [W-1:0]     res_next;
  logic [W-1:0]     result_q;
  logic             carry_q;
  logic             zero_q;
  logic [7:0]       lane_a;
  logic [7:0]       lane_b;
  logic             chain;

  alu_seq_ctrl #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ALU_SEQ_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .accept    (accept),
    .run       (run),
    .last      (last),
    .idx       (idx)
  );

  // Byte-lane select of the operands and merge of the ALU byte into the result
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    res_next = res_work;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        lane_a               = a_hold[8*i +: 8];
        lane_b               = b_hold[8*i +: 8];
        res_next[8*i +: 8]   = bus.alu_c;
      end
    end
  end

  // byte 0 only uses the carry-in when the command asks for it
  assign chain = (idx != '0) || cin_en_hold;

  assign bus.alu_a     = run ? lane_a : 8'd0;
  assign bus.alu_b     = run ? lane_b : 8'd0;
  assign bus.alu_carry = run ? carry_reg : 1'b0;
  assign bus.alu_op    = !run    ? OP_ADD :
                         sub_hold ? (chain ? OP_SBC : OP_SUB) :
                                    (chain ? OP_ADC : OP_ADD);

  // Operand capture, per-byte carry/zero chaining and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold      <= '0;
      b_hold      <= '0;
      sub_hold    <= 1'b0;
      cin_en_hold <= 1'b0;
      carry_reg   <= 1'b0;
      zero_acc    <= 1'b0;
      res_work    <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      if (accept) begin
        a_hold      <= bus.in_a;
        b_hold      <= bus.in_b;
        sub_hold    <= bus.in_cmd[CMD_SUB];
        cin_en_hold <= bus.in_cmd[CMD_CIN];
        carry_reg   <= bus.in_cmd[CMD_CIN] ? bus.in_cin : 1'b0;
        zero_acc    <= 1'b1;
      end
      if (run) begin
        res_work  <= res_next;
        carry_reg <= bus.alu_carry_out;
        zero_acc  <= zero_acc & bus.alu_zero;
      end
      // outputs only change when a command completes
      if (last) begin
        result_q <= res_next;
        carry_q  <= bus.alu_carry_out;
        zero_q   <= zero_acc & bus.alu_zero;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.out_result = result_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (NBYTES=4) with a behavioural
//               8-bit ALU on the ALU port and a result scoreboard.
//               Honours ALU_SEQ_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
`ifdef ALU_SEQ_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  alu_seq_if #(.NBYTES(NB)) bus ();

  alu_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef ALU_SEQ_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  // behavioural 8-bit ALU: carry_out is the borrow for SUB/SBC
  logic [8:0] alu_t;
  always_comb begin
    case (bus.alu_op)
      4'd0:    alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'd1:    alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_carry};
      4'd2:    alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'd3:    alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_carry};
      default: alu_t = {1'b0, bus.alu_a};
    endcase
  end
  assign bus.alu_c         = alu_t[7:0];
  assign bus.alu_carry_out = alu_t[8];
  assign bus.alu_zero      = (alu_t[7:0] == 8'd0);

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // wide add/sub over the low nbytes bytes; bit 8*nbytes is carry/borrow
  function automatic logic [63:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin, input int nbytes);
    logic [63:0] m;
    m = (64'd1 << (8 * nbytes)) - 64'd1;
    if (sub) return ({32'd0, a} & m) - ({32'd0, b} & m) - {63'd0, cin};
    else     return ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
  endfunction

  // scoreboard compare on every result handshake
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", bus.out_result, mon_e.r);
        check("out_carry",  bus.out_carry,  mon_e.c);
        check("out_zero",   bus.out_zero,   mon_e.z);
      end
    end
  end

  // accept one command; leaves the caller just after the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] cmd, input logic cin);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cmd   = cmd;
    bus.in_cin   = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_cmd   = 2'($urandom);
    bus.in_cin   = 1'($urandom);
  endtask

  task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] cmd, input logic cin, input int hold);
    logic [63:0] full;
    logic [63:0] part;
    logic        cin_eff;
    logic        exp_carry;
    exp_t        e;
    int          waitc;
    cin_eff = cmd[0] ? cin : 1'b0;
    full    = ref_sum(a, b, cmd[1], cin_eff, NB);
    e.r     = full[W-1:0];
    e.c     = full[W];
    e.z     = (full[W-1:0] == '0);
    send(a, b, cmd, cin);
    sb.push_back(e);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      if (k == 0) exp_carry = cin_eff;
      else begin
        part      = ref_sum(a, b, cmd[1], cin_eff, k);
        exp_carry = part[8*k];
      end
      check("alu_op",    bus.alu_op, {2'b00, cmd[1], (k != 0) || cmd[0]});
      check("alu_a",     bus.alu_a, (a >> (8*k)) & 32'hFF);
      check("alu_b",     bus.alu_b, (b >> (8*k)) & 32'hFF);
      check("alu_carry", bus.alu_carry, exp_carry);
      check("run_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b001);
    end
    waitc = 0;
    @(negedge clk);
    while (!bus.out_valid && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check("out_valid_latency", waitc, 0);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid",  {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
      check("hold_result", bus.out_result, e.r);
      check("alu_op_idle", bus.alu_op, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("post_keep", bus.out_result, e.r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cmd    = 2'd0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
    flush         = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_flags",  {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("rst_result", {bus.out_result, bus.out_carry, bus.out_zero}, 0);
    check("rst_alu",    {bus.alu_a, bus.alu_b, bus.alu_carry, bus.alu_op}, 0);
    rst_n = 1'b1;

    do_cmd(32'h0000_00FF, 32'h0000_0001, 2'd0, 1'b0, 0);
    do_cmd(32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 1'b0, 0);
    do_cmd(32'h0000_0005, 32'h0000_0003, 2'd2, 1'b0, 0);
    do_cmd(32'h0000_0000, 32'h0000_0000, 2'd1, 1'b1, 0);
    do_cmd(32'h1234_5678, 32'h0FED_CBA9, 2'd0, 1'b0, 5);
    do_cmd(32'h0000_0000, 32'h0000_0001, 2'd3, 1'b1, 1);

    // reset pulse during RUN byte 2 discards the command
    send(32'h8000_0001, 32'h8000_0001, 2'd1, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_before_rst", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_flags",  {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("arst_result", {bus.out_result, bus.out_carry, bus.out_zero}, 0);
    check("arst_alu",    {bus.alu_a, bus.alu_b, bus.alu_carry, bus.alu_op}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(32'hDEAD_BEEF, 32'h0000_1111, 2'd2, 1'b0, 0);

`ifdef ALU_SEQ_FLUSH_EN
    // flush on RUN byte 1 returns to IDLE with no result handshake
    send(32'h0000_0010, 32'h0000_0020, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {bus.in_ready, bus.busy}, 2'b10);
    for (int i = 0; i < 6; i++) begin
      check("flush_no_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    do_cmd(32'h0000_0010, 32'h0000_0020, 2'd0, 1'b0, 0);
`endif

    for (int r = 0; r < 4; r++) begin
      do_cmd(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), r);
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
